// File: rtl/seven_segment_scan_driver.sv
// +-----------------------------------------------------------------------------+
// | seven_segment_scan_driver : N-digit multiplexed 7-seg scanner with guard    |
// | slots, leading-zero blanking and frame-synchronous input capture.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seven_segment_scan_driver #(
  parameter int N   = 4,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4*N-1:0] din,
  input  logic [N-1:0]   dp_in,
  input  logic           blank_lz,
  output logic [6:0]     data_out,
  output logic           dp_out,
  output logic [N-1:0]   select,
  output logic           frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4*N-1:0]   sh_din_q, sh_din_d;
  logic [N-1:0]     sh_dp_q, sh_dp_d;
  logic             sh_blz_q, sh_blz_d;
  logic [6:0]       data_out_q, data_out_d;
  logic             dp_out_q, dp_out_d;
  logic [N-1:0]     select_q, select_d;
  logic             frame_done_q, frame_done_d;

  logic             hi_zero;
  logic [N-1:0]     lz_blank;
  logic [N-1:0]     onehot;
  logic [3:0]       nib;
  logic             nib_blank;
  logic             nib_dp;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    sh_din_d     = sh_din_q;
    sh_dp_d      = sh_dp_q;
    sh_blz_d     = sh_blz_q;
    frame_done_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        // Frame boundary: the only point where inputs become visible.
        idx_d        = '0;
        sh_din_d     = din;
        sh_dp_d      = dp_in;
        sh_blz_d     = blank_lz;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // Walk from the top digit down; a digit is blank while everything above it is zero.
    hi_zero  = 1'b1;
    lz_blank = '0;
    for (int i = N - 1; i >= 0; i--) begin
      hi_zero     = hi_zero & (sh_din_d[4*i +: 4] == 4'h0);
      lz_blank[i] = sh_blz_d & hi_zero & (i != 0);
    end

    onehot    = '0;
    nib       = '0;
    nib_blank = 1'b0;
    nib_dp    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (idx_d == IDX_W'(i)) begin
        onehot[i] = 1'b1;
        nib       = sh_din_d[4*i +: 4];
        nib_blank = lz_blank[i];
        nib_dp    = sh_dp_d[i];
      end
    end

    select_d   = '0;
    data_out_d = '0;
    dp_out_d   = 1'b0;
    if (cnt_d != '0) begin
      select_d   = onehot;
      data_out_d = nib_blank ? 7'h00 : hex_to_seg(nib);
      dp_out_d   = nib_dp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_din_q     <= '0;
      sh_dp_q      <= '0;
      sh_blz_q     <= 1'b0;
      data_out_q   <= '0;
      dp_out_q     <= 1'b0;
      select_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_din_q     <= sh_din_d;
      sh_dp_q      <= sh_dp_d;
      sh_blz_q     <= sh_blz_d;
      data_out_q   <= data_out_d;
      dp_out_q     <= dp_out_d;
      select_q     <= select_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign dp_out     = dp_out_q;
  assign select     = select_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: vector table, hand sequences and a
// random run against a slot-arithmetic reference model (N=4/DIV=4 and N=8/DIV=2).
`default_nettype none

module tb_seven_segment_scan_driver;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic [15:0] din4;
  logic [3:0]  dp4;
  logic        blz4;
  logic [6:0]  seg4;
  logic        dpo4;
  logic [3:0]  sel4;
  logic        fd4;

  logic [31:0] din8;
  logic [7:0]  dp8;
  logic        blz8;
  logic [6:0]  seg8;
  logic        dpo8;
  logic [7:0]  sel8;
  logic        fd8;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(.N(4), .DIV(4)) dut4 (
    .clk(clk), .reset(reset), .din(din4), .dp_in(dp4), .blank_lz(blz4),
    .data_out(seg4), .dp_out(dpo4), .select(sel4), .frame_done(fd4)
  );

  seven_segment_scan_driver #(.N(8), .DIV(2)) dut8 (
    .clk(clk), .reset(reset), .din(din8), .dp_in(dp8), .blank_lz(blz8),
    .data_out(seg8), .dp_out(dpo8), .select(sel8), .frame_done(fd8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] sel;
    logic       fd;
  } exp_t;

  // t = clock edges since reset release; shadow values as captured at the last boundary.
  function automatic exp_t model_out(int n, int div, int t, logic [31:0] sd, logic [7:0] sdp, logic sb);
    exp_t e;
    int   d, c;
    logic [31:0] upper;
    e = '0;
    d = (t / div) % n;
    c = t % div;
    e.fd = (t > 0) && (t % (n * div) == 0);
    if (c != 0) begin
      upper = sd >> (4 * d);
      e.sel = 8'(1 << d);
      e.dp  = sdp[d];
      if (!(sb && d >= 1 && upper == 0))
        e.seg = seg_tab[upper[3:0]];
    end
    return e;
  endfunction

  int          t4 = 0, t8 = 0;
  logic [31:0] m4_din = '0, m8_din = '0;
  logic [7:0]  m4_dp = '0, m8_dp = '0;
  logic        m4_blz = 1'b0, m8_blz = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t4 <= 0; m4_din <= '0; m4_dp <= '0; m4_blz <= 1'b0;
      t8 <= 0; m8_din <= '0; m8_dp <= '0; m8_blz <= 1'b0;
    end else begin
      t4 <= t4 + 1;
      t8 <= t8 + 1;
      if ((t4 + 1) % 16 == 0) begin
        m4_din <= {16'h0, din4}; m4_dp <= {4'h0, dp4}; m4_blz <= blz4;
      end
      if ((t8 + 1) % 16 == 0) begin
        m8_din <= din8; m8_dp <= dp8; m8_blz <= blz8;
      end
    end
  end

  always @(negedge clk) begin : model_check
    exp_t e4, e8;
    if (checking) begin
      e4 = model_out(4, 4, t4, m4_din, m4_dp, m4_blz);
      e8 = model_out(8, 2, t8, m8_din, m8_dp, m8_blz);
      chk("m4_seg", 32'(seg4), 32'(e4.seg));
      chk("m4_dp",  32'(dpo4), 32'(e4.dp));
      chk("m4_sel", 32'(sel4), 32'(e4.sel));
      chk("m4_fd",  32'(fd4),  32'(e4.fd));
      chk("m8_seg", 32'(seg8), 32'(e8.seg));
      chk("m8_dp",  32'(dpo8), 32'(e8.dp));
      chk("m8_sel", 32'(sel8), 32'(e8.sel));
      chk("m8_fd",  32'(fd8),  32'(e8.fd));
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [15:0]      din;
    logic [3:0]       dp;
    logic             blz;
    logic [3:0][6:0]  seg;   // expected segments per digit, [0] = digit 0
    logic [3:0]       dpx;   // expected dp_out per digit
  } vec_t;

  vec_t vecs [7];

  task automatic wait_frame(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (fd4 !== 1'b1 && waited < 100);
    chk("frame_done_seen", 32'(fd4), 32'd1);
  endtask

  // Called on the negedge where frame_done is high (state 0,0).
  task automatic check_frame(input vec_t v, input int change_k, input logic [15:0] change_din);
    int d, c;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      d = k / 4;
      c = k % 4;
      if (c != 0) begin
        chk("vec_seg", 32'(seg4), 32'(v.seg[d]));
        chk("vec_dp",  32'(dpo4), 32'(v.dpx[d]));
        chk("vec_sel", 32'(sel4), 32'(1 << d));
      end else begin
        chk("vec_guard_sel", 32'(sel4), 32'd0);
        chk("vec_guard_seg", 32'(seg4), 32'd0);
      end
      chk("vec_fd_low", 32'(fd4), 32'd0);
      if (k == change_k) din4 = change_din;
    end
  endtask

  logic [3:0] exp_sel [16] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd2,
                               4'd0, 4'd4, 4'd4, 4'd4, 4'd0, 4'd8, 4'd8, 4'd8};

  initial begin
    int   w;
    vec_t v1234;

    vecs[0] = '{din:16'h12AF, dp:4'b0000, blz:1'b0, seg:{7'h06, 7'h5B, 7'h77, 7'h71}, dpx:4'b0000};
    vecs[1] = '{din:16'h1111, dp:4'b0000, blz:1'b0, seg:{7'h06, 7'h06, 7'h06, 7'h06}, dpx:4'b0000};
    vecs[2] = '{din:16'h2222, dp:4'b0000, blz:1'b0, seg:{7'h5B, 7'h5B, 7'h5B, 7'h5B}, dpx:4'b0000};
    vecs[3] = '{din:16'h0050, dp:4'b0000, blz:1'b1, seg:{7'h00, 7'h00, 7'h6D, 7'h3F}, dpx:4'b0000};
    vecs[4] = '{din:16'h0000, dp:4'b0000, blz:1'b1, seg:{7'h00, 7'h00, 7'h00, 7'h3F}, dpx:4'b0000};
    vecs[5] = '{din:16'h0000, dp:4'b0100, blz:1'b0, seg:{7'h3F, 7'h3F, 7'h3F, 7'h3F}, dpx:4'b0100};
    vecs[6] = '{din:16'h8D0E, dp:4'b1001, blz:1'b1, seg:{7'h7F, 7'h5E, 7'h3F, 7'h79}, dpx:4'b1001};
    v1234   = '{din:16'h1234, dp:4'b0000, blz:1'b0, seg:{7'h06, 7'h5B, 7'h4F, 7'h66}, dpx:4'b0000};

    din4 = 16'h12AF; dp4 = '0; blz4 = 1'b0;
    din8 = 32'h0; dp8 = '0; blz8 = 1'b0;

    // Reset held for 3 cycles, then scan order of the first frame.
    #1 reset = 1'b1;
    checking = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_seg", 32'(seg4), 32'd0);
      chk("rst_sel", 32'(sel4), 32'd0);
      chk("rst_dp",  32'(dpo4), 32'd0);
      chk("rst_fd",  32'(fd4),  32'd0);
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      chk("scan_sel", 32'(sel4), 32'(exp_sel[k]));
      chk("scan_seg", 32'(seg4), (exp_sel[k] != 4'd0) ? 32'h3F : 32'h0);
      chk("scan_fd",  32'(fd4),  32'd0);
    end

    // First captured value: frame_done on the very next cycle (cycle 16).
    wait_frame(w);
    chk("capture_cycle16", 32'(w), 32'd1);
    check_frame(vecs[0], -1, 16'h0);

    // Table; vector 1 changes din mid-frame (digit 1 active) to check no tearing.
    for (int i = 1; i < 7; i++) begin
      din4 = vecs[i].din; dp4 = vecs[i].dp; blz4 = vecs[i].blz;
      wait_frame(w);
      check_frame(vecs[i], (i == 1) ? 5 : -1, 16'h2222);
    end

    // Asynchronous reset during digit 2.
    din4 = 16'h1234; dp4 = '0; blz4 = 1'b0;
    din8 = 32'hCAFE_0042;
    wait_frame(w);
    repeat (9) @(negedge clk);
    chk("pre_rst_sel", 32'(sel4), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("async_seg4", 32'(seg4), 32'd0);
    chk("async_sel4", 32'(sel4), 32'd0);
    chk("async_dp4",  32'(dpo4), 32'd0);
    chk("async_fd4",  32'(fd4),  32'd0);
    chk("async_sel8", 32'(sel8), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_sel", 32'(sel4), 32'd1);
    chk("restart_seg", 32'(seg4), 32'h3F);
    wait_frame(w);
    chk("restart_latency", 32'(w), 32'd15);
    check_frame(v1234, -1, 16'h0);

    // N=8, DIV=2: frame period 16, eight one-hot codes.
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (fd8 !== 1'b1 && w < 100);
    chk("n8_frame_seen", 32'(fd8), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16) begin
        chk("n8_sel", 32'(sel8), (k % 2 != 0) ? 32'(1 << (k / 2)) : 32'd0);
        chk("n8_fd_low", 32'(fd8), 32'd0);
      end else begin
        chk("n8_period", 32'(fd8), 32'd1);
      end
    end

    // Random run against the model, with one asynchronous reset mid-way.
    for (int n = 0; n < 900; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        din4 = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp4  = 4'($urandom);
        blz4 = 1'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        din8 = $urandom >> (4 * $urandom_range(0, 8));
        dp8  = 8'($urandom);
        blz8 = 1'($urandom);
      end
      if (n == 450) begin
        #3 reset = 1'b1;
        #10 reset = 1'b0;
      end
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
